// File: rtl/smoke_inc_server.sv
// smoke_inc_server
//
// Request/response increment engine used as the hardware target of the smoke
// BFM's inc method. Tagged requests are queued in a DEPTH-entry FIFO and come
// back in order as data+1 over a backpressured response channel.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = FIFO not full)
//   req_id, req_data      request tag and operand
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_data      tag and incremented operand of the presented response
//   rsp_wrap              operand was all-ones, result wrapped to zero
//   count                 current FIFO occupancy
//   busy                  FIFO non-empty or response presented
//
// Optional feature (macro SMOKE_INC_SERVER_STATS_EN):
//   stat_req_cnt, stat_rsp_cnt  32-bit wrapping handshake counters

module smoke_inc_server #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ID_WIDTH-1:0]        req_id,
  input  logic [DATA_WIDTH-1:0]      req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_wrap,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
`ifdef SMOKE_INC_SERVER_STATS_EN
  ,
  output logic [31:0]                stat_req_cnt,
  output logic [31:0]                stat_rsp_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state;

  logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // req_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot early and there is no path from rsp_ready to req_ready.
  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;

  // The head is moved into the response registers whenever nothing is being
  // presented, or the presented response is being consumed this cycle.
  assign pop  = (count != '0) && ((state == IDLE) || rsp_ready);
  assign busy = (count != '0) || rsp_valid;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) begin
      id_mem[wr_ptr]   <= req_id;
      data_mem[wr_ptr] <= req_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response FSM. The response registers are loaded straight from the FIFO
  // head, so a consumed response can be replaced in the same edge and
  // back-to-back responses need no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_wrap  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            rsp_id    <= id_mem[rd_ptr];
            rsp_data  <= data_mem[rd_ptr] + DATA_WIDTH'(1);
            rsp_wrap  <= &data_mem[rd_ptr];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (pop) begin
              rsp_id   <= id_mem[rd_ptr];
              rsp_data <= data_mem[rd_ptr] + DATA_WIDTH'(1);
              rsp_wrap <= &data_mem[rd_ptr];
            end else begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SMOKE_INC_SERVER_STATS_EN
  // Handshake counters, free-running and wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_req_cnt <= '0;
      stat_rsp_cnt <= '0;
    end else begin
      if (push)                   stat_req_cnt <= stat_req_cnt + 32'd1;
      if (rsp_valid && rsp_ready) stat_rsp_cnt <= stat_rsp_cnt + 32'd1;
    end
  end
`endif

endmodule
